mul_product_unloader: RTL and testbench

- Drain side of the unsigned 8x8 radix-8 multiplier datapath. Operand enable registers load the multiplier's inputs; this block takes the finished products away from its output.
- Accepts full-width products over a valid/ready interface and buffers them in a small FIFO.
- Serializes each product into OUT_WIDTH-bit beats on a downstream valid/ready stream, with a last-beat marker.

---
 rtl/mul_product_unloader.sv | 199 +++++++++++++++++++
 tb/tb_mul_product_unloader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_product_unloader.sv
// mul_product_unloader
// Drain side of the unsigned 8x8 radix-8 multiplier. Finished products are
// accepted over a valid/ready interface, buffered in a small circular FIFO and
// serialized into OUT_WIDTH-bit beats on a downstream valid/ready stream with
// a last-beat marker.
//
// Optional build macro: UNLOAD_MSB_FIRST_EN
//   undefined (default): beats leave least-significant first
//   defined            : beats leave most-significant first
// Handshake, latency and capacity are identical in both builds.

module mul_product_unloader #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 8,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iVld,
  input  logic [DATA_WIDTH-1:0] iDat,
  output logic                  oRdy,
  output logic                  oVld,
  output logic [OUT_WIDTH-1:0]  oDat,
  output logic                  oLast,
  input  logic                  iRdy,
  output logic                  oBusy
);

  localparam int BEATS  = DATA_WIDTH / OUT_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [PTR_W-1:0]  PTR_MAX   = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Registered state
  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [BEAT_W-1:0]       beat_q,  beat_d;
  logic [PTR_W-1:0]        wptr_q,  wptr_d;
  logic [PTR_W-1:0]        rptr_q,  rptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];

  // Combinational helpers
  logic                    full_s;
  logic                    empty_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    handshake_s;
  logic [DATA_WIDTH-1:0]   shift_next_s;
  logic [OUT_WIDTH-1:0]    beat_view_s;

  // Circular pointer advance; wraps modulo DEPTH (DEPTH is a power of two,
  // but the explicit compare also covers DEPTH == 1).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == PTR_MAX) begin
      r = PTR_W'(0);
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  assign full_s      = (count_q == CNT_FULL);
  assign empty_s     = (count_q == CNT_ZERO);
  // Ready comes only from the registered count: a pop that frees a slot
  // raises oRdy one cycle later, never within the same cycle.
  assign oRdy        = !rst && !full_s;
  assign push_s      = iVld && oRdy;
  assign handshake_s = (state_q == ST_SEND) && iRdy;

  // Beat selection and next-beat shift, chosen by the beat-order build option
  always_comb begin
`ifdef UNLOAD_MSB_FIRST_EN
    beat_view_s  = shift_q[DATA_WIDTH-1 -: OUT_WIDTH];
    shift_next_s = shift_q << OUT_WIDTH;
`else
    beat_view_s  = shift_q[OUT_WIDTH-1:0];
    shift_next_s = shift_q >> OUT_WIDTH;
`endif
  end

  // Serializer FSM: load from FIFO head, walk the beats, chain products without a bubble
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    beat_d  = beat_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_d = mem_q[rptr_q];
          beat_d  = BEAT_W'(0);
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (handshake_s) begin
          if (beat_q != LAST_BEAT) begin
            shift_d = shift_next_s;
            beat_d  = beat_q + BEAT_W'(1);
          end else if (!empty_s) begin
            pop_s   = 1'b1;
            shift_d = mem_q[rptr_q];
            beat_d  = BEAT_W'(0);
            state_d = ST_SEND;
          end else begin
            beat_d  = BEAT_W'(0);
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = BEAT_W'(0);
      end
    endcase
  end

  // FIFO storage, pointers and occupancy; push and pop together keep the count
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_s) begin
      mem_d[wptr_q] = iDat;
      wptr_d        = ptr_inc(wptr_q);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = ptr_inc(rptr_q);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Downstream outputs derived purely from registered state
  always_comb begin
    oVld  = 1'b0;
    oDat  = {OUT_WIDTH{1'b0}};
    oLast = 1'b0;
    if (state_q == ST_SEND) begin
      oVld  = 1'b1;
      oDat  = beat_view_s;
      oLast = (beat_q == LAST_BEAT);
    end else begin
      oVld  = 1'b0;
    end
    oBusy = !empty_s || (state_q == ST_SEND);
  end

  // State register with synchronous reset that discards everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= {DATA_WIDTH{1'b0}};
      beat_q  <= BEAT_W'(0);
      wptr_q  <= PTR_W'(0);
      rptr_q  <= PTR_W'(0);
      count_q <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      beat_q  <= beat_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mul_product_unloader.sv
// Self-checking bench for mul_product_unloader: a queue-based product model
// predicts every output each cycle, and directed scenarios pin the observed
// beat streams against hand-computed literals.
`timescale 1ns/1ps

module tb_mul_product_unloader;

  localparam int DW    = 16;
  localparam int OW    = 8;
  localparam int DP    = 2;
  localparam int BEATS = DW / OW;

  logic          clk = 1'b0;
  logic          rst;
  logic          iVld;
  logic [DW-1:0] iDat;
  logic          oRdy;
  logic          oVld;
  logic [OW-1:0] oDat;
  logic          oLast;
  logic          iRdy;
  logic          oBusy;

  mul_product_unloader #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .iVld(iVld), .iDat(iDat), .oRdy(oRdy),
    .oVld(oVld), .oDat(oDat), .oLast(oLast), .iRdy(iRdy), .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  // Model state: queued products, product being sent and its beat index
  logic [DW-1:0] m_fifo [$];
  logic [DW-1:0] m_cur;
  int            m_beat;
  bit            m_send;
  bit            m_acc;
  bit            started;
  int            cyc;

  int n_cmp;
  int n_bad;

  logic [8:0] got  [$];
  int         gotc [$];
  logic [8:0] exp_q [$];

  function automatic logic [OW-1:0] beat_of(input logic [DW-1:0] p, input int i);
`ifdef UNLOAD_MSB_FIRST_EN
    return p[(DW - OW - i*OW) +: OW];
`else
    return p[i*OW +: OW];
`endif
  endfunction

  // Model advance at each rising edge from the inputs held since the last edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_fifo.delete();
      m_send  = 1'b0;
      m_beat  = 0;
      m_acc   = 1'b0;
      started = 1'b1;
    end else begin
      m_acc = iVld && (m_fifo.size() < DP);
      if (!m_send) begin
        if (m_fifo.size() > 0) begin
          m_cur  = m_fifo.pop_front();
          m_beat = 0;
          m_send = 1'b1;
        end
      end else if (iRdy) begin
        if (m_beat < BEATS-1) begin
          m_beat = m_beat + 1;
        end else if (m_fifo.size() > 0) begin
          m_cur  = m_fifo.pop_front();
          m_beat = 0;
        end else begin
          m_send = 1'b0;
        end
      end
      if (m_acc) m_fifo.push_back(iDat);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    int n;
    n = 0;
    iVld = 1'b1;
    iDat = v;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!m_acc && n < 300);
    chk("push_accept", (n < 300), 1);
    iVld = 1'b0;
    iDat = DW'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_fifo.size() != 0 || m_send) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", (n < 300), 1);
    @(posedge clk); #1;
  endtask

  task automatic check_got(input string nm);
    chk({nm, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk(nm, got[i], exp_q[i]);
    end
    got.delete();
    gotc.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; iVld = 1'b0; iDat = '0; iRdy = 1'b1;
    n_cmp = 0; n_bad = 0; cyc = 0; started = 1'b0;
    m_send = 1'b0; m_beat = 0; m_acc = 1'b0; m_cur = '0;
    fork
      // Per-cycle comparison against the model, plus beat capture
      forever begin
        @(negedge clk);
        if (started) begin
          chk("oRdy",  oRdy,  (!rst && m_fifo.size() < DP));
          chk("oVld",  oVld,  m_send);
          chk("oLast", oLast, (m_send && m_beat == BEATS-1));
          chk("oDat",  oDat,  (m_send ? beat_of(m_cur, m_beat) : 8'h00));
          chk("oBusy", oBusy, (m_fifo.size() > 0 || m_send));
          if (!rst && oVld && iRdy) begin
            got.push_back({oLast, oDat});
            gotc.push_back(cyc);
          end
        end
      end
      begin
        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_oRdy", oRdy, 0);
        chk("rst_oVld", oVld, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_oRdy", oRdy, 1);
        chk("post_rst_oBusy", oBusy, 0);

        // Single product
        push(16'hBEEF);
`ifdef UNLOAD_MSB_FIRST_EN
        exp_q = '{9'h0BE, 9'h1EF};
`else
        exp_q = '{9'h0EF, 9'h1BE};
`endif
        drain();
        check_got("single");
        chk("single_idle_vld", oVld, 0);
        chk("single_idle_busy", oBusy, 0);

        // Back-to-back
        push(16'hFE01);
        push(16'h0000);
        push(16'h0001);
        drain();
        if (gotc.size() >= 6) chk("b2b_gap", gotc[5] - gotc[0], 5);
        else chk("b2b_beats", gotc.size(), 6);
`ifndef UNLOAD_MSB_FIRST_EN
        exp_q = '{9'h001, 9'h1FE, 9'h000, 9'h100, 9'h001, 9'h100};
        check_got("b2b");
`else
        got.delete(); gotc.delete();
`endif

        // Backpressure
        iRdy = 1'b0;
        push(16'h1234);
        push(16'h5678);
        push(16'h9ABC);
        iVld = 1'b1;
        iDat = 16'hDEF0;
        repeat (4) begin
          @(negedge clk);
          chk("bp_oRdy", oRdy, 0);
          chk("bp_oVld", oVld, 1);
`ifdef UNLOAD_MSB_FIRST_EN
          chk("bp_oDat", oDat, 8'h12);
`else
          chk("bp_oDat", oDat, 8'h34);
`endif
        end
        @(posedge clk); #1;
        chk("bp_not_taken", m_acc, 0);
        iRdy = 1'b1;
        push(16'hDEF0);
        drain();
`ifndef UNLOAD_MSB_FIRST_EN
        exp_q = '{9'h034, 9'h112, 9'h078, 9'h156, 9'h0BC, 9'h19A, 9'h0F0, 9'h1DE};
        check_got("bp");
`else
        got.delete(); gotc.delete();
`endif

        // Wrap-around with toggling downstream ready
        fork
          begin
            for (int k = 1; k <= 10; k++) push(16'h0101 * 16'(k));
          end
          begin
            repeat (70) begin
              @(posedge clk); #1;
              iRdy = ~iRdy;
            end
          end
        join
        iRdy = 1'b1;
        drain();
        for (int k = 1; k <= 10; k++) begin
          exp_q.push_back({1'b0, 8'(k)});
          exp_q.push_back({1'b1, 8'(k)});
        end
        check_got("wrap");

        // Reset mid-operation
        iRdy = 1'b0;
        push(16'hA5C3);
        push(16'h1111);
        @(negedge clk);
`ifdef UNLOAD_MSB_FIRST_EN
        chk("mid_oDat", oDat, 8'hA5);
`else
        chk("mid_oDat", oDat, 8'hC3);
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_oVld", oVld, 0);
        chk("mid_oBusy", oBusy, 0);
        iRdy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_no_beats", got.size(), 0);
        push(16'h0F0F);
        drain();
        exp_q = '{9'h00F, 9'h10F};
        check_got("mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    join
  end

endmodule
